// File: rtl/tdp_ram_be.sv
// rtl/tdp_ram_be.sv - true dual-port byte-enable RAM with clear-on-reset and 1/2-cycle read pipeline
module tdp_ram_be #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int DEPTH      = 64,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    localparam int BE_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [BE_W-1:0]   be_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [BE_W-1:0]   be_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              collision
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign init_busy = (state_q == ST_INIT);

    logic              ready, acc_a, acc_b, in_a, in_b, wr_a, wr_b, hit, collide;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rb_a, rb_b;

    assign ready   = (state_q == ST_READY) && !rst;
    assign acc_a   = ready && en_a;
    assign acc_b   = ready && en_b;
    assign in_a    = 32'(addr_a) < DEPTH;
    assign in_b    = 32'(addr_b) < DEPTH;
    assign idx_a   = addr_a[IDX_W-1:0];
    assign idx_b   = addr_b[IDX_W-1:0];
    assign old_a   = in_a ? mem_q[idx_a] : '0;
    assign old_b   = in_b ? mem_q[idx_b] : '0;
    assign wr_a    = acc_a && we_a && in_a;
    assign wr_b    = acc_b && we_b && in_b;
    assign hit     = acc_a && acc_b && in_a && (addr_a == addr_b);
    assign collide = hit && (we_a || we_b);

    // Post-write word as seen by each port; on a shared address port A owns contested lanes.
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < BE_W; i++) begin
            if (hit && wr_b && be_b[i]) new_a[8*i +: 8] = wdata_b[8*i +: 8];
            if (wr_a && be_a[i])        new_a[8*i +: 8] = wdata_a[8*i +: 8];
            if (wr_b && be_b[i])        new_b[8*i +: 8] = wdata_b[8*i +: 8];
            if (hit && wr_a && be_a[i]) new_b[8*i +: 8] = wdata_a[8*i +: 8];
        end
    end

    // A reading port always sees the old word; only the writer's own readback honours write-first.
    assign rb_a = (we_a && RDW_MODE == 1) ? new_a : old_a;
    assign rb_b = (we_b && RDW_MODE == 1) ? new_b : old_b;

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[ptr_q] <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_b && be_b[i]) mem_q[idx_b][8*i +: 8] <= wdata_b[8*i +: 8];
                if (wr_a && be_a[i]) mem_q[idx_a][8*i +: 8] <= wdata_a[8*i +: 8];
            end
        end
    end

    logic              rv_a1_q, rv_b1_q, col1_q;
    logic [DATA_W-1:0] rd_a1_q, rd_b1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rv_a1_q <= 1'b0;
            rv_b1_q <= 1'b0;
            col1_q  <= 1'b0;
            rd_a1_q <= '0;
            rd_b1_q <= '0;
        end else begin
            rv_a1_q <= acc_a;
            rv_b1_q <= acc_b;
            col1_q  <= collide;
            if (acc_a) rd_a1_q <= rb_a;
            if (acc_b) rd_b1_q <= rb_b;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              rv_a2_q, rv_b2_q, col2_q;
            logic [DATA_W-1:0] rd_a2_q, rd_b2_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rv_a2_q <= 1'b0;
                    rv_b2_q <= 1'b0;
                    col2_q  <= 1'b0;
                    rd_a2_q <= '0;
                    rd_b2_q <= '0;
                end else begin
                    rv_a2_q <= rv_a1_q;
                    rv_b2_q <= rv_b1_q;
                    col2_q  <= col1_q;
                    if (rv_a1_q) rd_a2_q <= rd_a1_q;
                    if (rv_b1_q) rd_b2_q <= rd_b1_q;
                end
            end

            assign rvalid_a  = rv_a2_q;
            assign rvalid_b  = rv_b2_q;
            assign rdata_a   = rd_a2_q;
            assign rdata_b   = rd_b2_q;
            assign collision = col2_q;
        end else begin : g_lat1
            assign rvalid_a  = rv_a1_q;
            assign rvalid_b  = rv_b1_q;
            assign rdata_a   = rd_a1_q;
            assign rdata_b   = rd_b1_q;
            assign collision = col1_q;
        end
    endgenerate

endmodule
